// File: rtl/gate_pkg.sv
// Shared types, gate codes and truth-table constants for the gate truth-table prober.
package gate_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} probe_state_t;

   typedef logic [2:0] gate_id_t;

   localparam gate_id_t GID_UNKNOWN = 3'd0;
   localparam gate_id_t GID_AND     = 3'd1;
   localparam gate_id_t GID_OR      = 3'd2;
   localparam gate_id_t GID_NAND    = 3'd3;
   localparam gate_id_t GID_NOR     = 3'd4;
   localparam gate_id_t GID_XOR     = 3'd5;
   localparam gate_id_t GID_XNOR    = 3'd6;

   // Truth tables indexed by {a,b}
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   function automatic gate_id_t classify(input logic [3:0] tt);
      gate_id_t id;
      case (tt)
         TT_AND:  id = GID_AND;
         TT_OR:   id = GID_OR;
         TT_NAND: id = GID_NAND;
         TT_NOR:  id = GID_NOR;
         TT_XOR:  id = GID_XOR;
         TT_XNOR: id = GID_XNOR;
         default: id = GID_UNKNOWN;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/gate_tt_prober.sv
// Stimulus/response engine: walks {a,b} through all four vectors, samples the synchronized
// gate output, then classifies the captured truth table and compares it with the expected one.
module gate_tt_prober
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] expect_tt,
   output logic       a,
   output logic       b,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth_table,
   output gate_id_t   gate_id,
   output logic       match
);

   localparam int unsigned HOLD_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
   localparam int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   probe_state_t     state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       exp_q, exp_d;
   logic [3:0]       tt_q, tt_d;
   gate_id_t         gid_q, gid_d;
   logic             a_q, a_d, b_q, b_d;
   logic             busy_q, busy_d, done_q, done_d, match_q, match_d;
   logic             y_sync;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_y (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (y),
      .q     (y_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         gid_q   <= GID_UNKNOWN;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tt_q    <= tt_d;
         gid_q   <= gid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         match_q <= match_d;
      end
   end

   // Next-state and next-output logic; a/b stay on the vector through its SAMPLE cycle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tt_d    = tt_q;
      gid_d   = gid_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      match_d = match_q;

      case (state_q)
         IDLE: begin
            a_d    = 1'b0;
            b_d    = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               state_d = DRIVE;
               idx_d   = '0;
               cnt_d   = '0;
               exp_d   = expect_tt;
               tt_d    = '0;
               gid_d   = GID_UNKNOWN;
               match_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            tt_d[idx_q] = y_sync;
            if (idx_q == 2'd3) begin
               state_d = DONE;
               done_d  = 1'b1;
               gid_d   = classify(tt_d);
               match_d = (tt_d == exp_q);
               a_d     = 1'b0;
               b_d     = 1'b0;
            end else begin
               state_d    = DRIVE;
               idx_d      = idx_q + 2'd1;
               cnt_d      = '0;
               {a_d, b_d} = idx_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign a           = a_q;
   assign b           = b_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign truth_table = tt_q;
   assign gate_id     = gid_q;
   assign match       = match_q;

endmodule

// File: tb/tb_gate_tt_prober.sv
// Randomized and directed bench for gate_tt_prober against a truth-table level reference model.
module tb_gate_tt_prober;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] expect_tt;
   logic       a, b, y;
   logic       busy, done, match;
   logic [3:0] truth_table;
   logic [2:0] gate_id;
   logic [3:0] model_tt;

   int errors = 0;
   int checks = 0;

   // Known gate tables in gate_id order 1..6
   logic [3:0] known_tt [6] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

   always #5 clk = ~clk;

   // Gate under test modelled combinationally from its truth table
   assign y = model_tt[{a, b}];

   gate_tt_prober dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .expect_tt   (expect_tt),
      .a           (a),
      .b           (b),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .truth_table (truth_table),
      .gate_id     (gate_id),
      .match       (match)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_gid(input logic [3:0] tt);
      for (int i = 0; i < 6; i++) begin
         if (known_tt[i] == tt) return 3'(i + 1);
      end
      return 3'd0;
   endfunction

   // One probe run; start accepted at the edge after the first negedge, cycle n observed at negedge n
   task automatic run_probe(input logic [3:0] gtt, input logic [3:0] exp,
                            input int repulse, input bit start_at_done);
      int dones = 0;
      @(negedge clk);
      model_tt  = gtt;
      expect_tt = exp;
      start     = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (done) dones++;
         chk("done", 32'(done), 32'(n == 21));
         chk("busy", 32'(busy), 32'(n <= 21));
         if (n <= 20) chk("ab_seq", 32'({a, b}), 32'((n - 1) / 5));
         else         chk("ab_idle", 32'({a, b}), 32'd0);
         if (n >= 21) begin
            chk("truth_table", 32'(truth_table), 32'(gtt));
            chk("gate_id", 32'(gate_id), 32'(ref_gid(gtt)));
            chk("match", 32'(match), 32'(gtt == exp));
         end
         start = (n == repulse) || (start_at_done && n == 21);
         if (n == 1) expect_tt = ~exp;
      end
      start = 1'b0;
      chk("done_count", 32'(dones), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      expect_tt = 4'h0;
      model_tt  = 4'h0;

      @(negedge clk);
      chk("rst_outputs", 32'({a, b, busy, done, truth_table, gate_id, match}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_probe(4'b0001, 4'h1, 0, 1'b0);   // NOR, match
      run_probe(4'b0111, 4'h1, 0, 1'b0);   // NAND, mismatch
      run_probe(4'b0000, 4'h0, 0, 1'b0);   // stuck at 0
      run_probe(4'b1111, 4'h6, 0, 1'b0);   // stuck at 1
      run_probe(4'b0110, 4'h6, 7, 1'b1);   // XOR, re-pulse mid-run and start during DONE

      // Reset mid-run at cycle 12
      begin
         @(negedge clk);
         model_tt  = 4'b1110;
         expect_tt = 4'b1110;
         start     = 1'b1;
         for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = 1'b0;
         end
         rst_n = 1'b0;
         #1;
         chk("midrun_rst_ab", 32'({a, b}), 32'd0);
         chk("midrun_rst_busy", 32'(busy), 32'd0);
         chk("midrun_rst_tt", 32'(truth_table), 32'd0);
         chk("midrun_rst_gid_match", 32'({gate_id, match, done}), 32'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({busy, done}), 32'd0);
         end
      end
      run_probe(4'b1110, 4'b1110, 0, 1'b0);

      // start held high across two runs
      begin
         int cnt = 0;
         int first = 0;
         int second = 0;
         @(negedge clk);
         model_tt  = 4'b1001;
         expect_tt = 4'b1001;
         start     = 1'b1;
         for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (done) begin
               cnt++;
               if (cnt == 1) first = n;
               else if (cnt == 2) begin
                  second = n;
                  start  = 1'b0;
               end
            end
            if (n == 22) chk("held_gap_busy", 32'(busy), 32'd0);
            if (n == 23) chk("held_rerun_busy", 32'(busy), 32'd1);
         end
         chk("held_done_count", 32'(cnt), 32'd2);
         chk("held_first_done", 32'(first), 32'd21);
         chk("held_second_done", 32'(second), 32'd43);
         chk("held_gate_id", 32'(gate_id), 32'(ref_gid(4'b1001)));
      end

      // Randomized tables and expectations
      for (int r = 0; r < 10; r++) begin
         logic [3:0] gtt;
         logic [3:0] ex;
         gtt = ($urandom % 2 == 0) ? known_tt[$urandom % 6] : 4'($urandom);
         ex  = ($urandom % 2 == 0) ? gtt : 4'($urandom);
         run_probe(gtt, ex, ($urandom % 3 == 0) ? int'($urandom_range(1, 20)) : 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
